// File: rtl/soi_obs_pkg.sv
// Shared types and default sizes for the signal-of-interest observer.
// The record struct documents the record layout at the default widths.
package soi_obs_pkg;

    localparam int PROBE_W_DEF = 3;
    localparam int DEPTH_DEF   = 8;
    localparam int TS_W_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STOPPED = 2'd2
    } obs_state_e;

    typedef struct packed {
        logic [TS_W_DEF-1:0]    ts;
        logic [PROBE_W_DEF-1:0] probe;
    } obs_rec_t;

    function automatic logic [TS_W_DEF+PROBE_W_DEF-1:0] pack_rec(
        input logic [TS_W_DEF-1:0]    ts,
        input logic [PROBE_W_DEF-1:0] probe
    );
        obs_rec_t r;
        r.ts    = ts;
        r.probe = probe;
        return r;
    endfunction

endpackage

// File: rtl/soi_rec_fifo.sv
// Record buffer: synchronous FIFO with flush, and push+pop allowed together when full.
// Read data is the head entry, valid whenever the FIFO is non-empty.
module soi_rec_fifo
    import soi_obs_pkg::*;
#(
    parameter int W     = TS_W_DEF + PROBE_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        full_o  = (count_q == CW'(DEPTH));
        empty_o = (count_q == '0);
        pop_ok  = pop_i && !empty_o;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push_ok = push_i && (!full_o || pop_ok);
        rdata_o = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (!push_ok && pop_ok) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/soi_observer.sv
// Signal-of-interest observer: timestamps every probe change during capture into a
// record FIFO, which the host drains one record per rd_req.
module soi_observer
    import soi_obs_pkg::*;
#(
    parameter int PROBE_W = PROBE_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TS_W    = TS_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PROBE_W-1:0]     probe,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   rd_req,
    output logic                   rd_valid,
    output logic [TS_W-1:0]        rd_ts,
    output logic [PROBE_W-1:0]     rd_probe,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   capturing,
    output obs_state_e             dbg_state
);

    localparam int RW = TS_W + PROBE_W;
    localparam int CW = $clog2(DEPTH) + 1;

    obs_state_e         state_q;
    logic [TS_W-1:0]    ts_q;
    logic [PROBE_W-1:0] prev_q;
    logic               first_q;
    logic               overflow_q;
    logic               capturing_q;
    logic               rd_valid_q;
    logic [TS_W-1:0]    rd_ts_q;
    logic [PROBE_W-1:0] rd_probe_q;

    logic               push_req;
    logic               pop_req;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [RW-1:0]      fifo_wdata;
    logic [RW-1:0]      fifo_rdata;
    logic [CW-1:0]      fifo_count;

    soi_rec_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (arm),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // arm flushes the buffer, so neither a push nor a pop may happen alongside it.
    always_comb begin
        push_req   = (state_q == CAPTURE) && !arm && (first_q || (probe != prev_q));
        pop_req    = rd_req && !arm && !fifo_empty;
        drop       = push_req && fifo_full && !pop_req;
        fifo_wdata = {ts_q, probe};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            prev_q      <= '0;
            first_q     <= 1'b0;
            overflow_q  <= 1'b0;
            capturing_q <= 1'b0;
        end else if (arm) begin
            state_q     <= CAPTURE;
            ts_q        <= '0;
            prev_q      <= probe;
            first_q     <= 1'b1;
            overflow_q  <= 1'b0;
            capturing_q <= 1'b1;
        end else begin
            case (state_q)
                CAPTURE: begin
                    ts_q    <= ts_q + TS_W'(1);
                    prev_q  <= probe;
                    first_q <= 1'b0;
                    if (drop) overflow_q <= 1'b1;
                    if (stop) begin
                        state_q     <= STOPPED;
                        capturing_q <= 1'b0;
                    end
                end
                default: begin
                    capturing_q <= 1'b0;
                end
            endcase
        end
    end

    // Read data holds the last popped record until the next pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_ts_q    <= '0;
            rd_probe_q <= '0;
        end else begin
            rd_valid_q <= pop_req;
            if (pop_req) begin
                rd_ts_q    <= fifo_rdata[RW-1:PROBE_W];
                rd_probe_q <= fifo_rdata[PROBE_W-1:0];
            end
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_ts     = rd_ts_q;
    assign rd_probe  = rd_probe_q;
    assign count     = fifo_count;
    assign overflow  = overflow_q;
    assign capturing = capturing_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_soi_observer.sv
// Directed bench for soi_observer: a scoreboard queue holds the records expected in
// the buffer; popped entries are compared against the read port of two instances.
module tb_soi_observer;
    import soi_obs_pkg::*;

    localparam int PROBE_W = 3;
    localparam int DEPTH   = 8;
    localparam int TS_W    = 16;
    localparam int TS2_W   = 4;
    localparam int RW      = TS_W + PROBE_W;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk;
    logic               reset;
    logic [PROBE_W-1:0] probe;
    logic               arm;
    logic               stop;
    logic               rd_req;

    logic               rd_valid, rd_valid2;
    logic [TS_W-1:0]    rd_ts;
    logic [TS2_W-1:0]   rd_ts2;
    logic [PROBE_W-1:0] rd_probe, rd_probe2;
    logic [CW-1:0]      count, count2;
    logic               overflow, overflow2;
    logic               capturing, capturing2;
    obs_state_e         dbg_state, dbg_state2;

    soi_observer #(.PROBE_W(PROBE_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .reset(reset), .probe(probe), .arm(arm), .stop(stop), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_ts(rd_ts), .rd_probe(rd_probe), .count(count),
        .overflow(overflow), .capturing(capturing), .dbg_state(dbg_state)
    );

    soi_observer #(.PROBE_W(PROBE_W), .DEPTH(DEPTH), .TS_W(TS2_W)) dut_ts4 (
        .clk(clk), .reset(reset), .probe(probe), .arm(arm), .stop(stop), .rd_req(rd_req),
        .rd_valid(rd_valid2), .rd_ts(rd_ts2), .rd_probe(rd_probe2), .count(count2),
        .overflow(overflow2), .capturing(capturing2), .dbg_state(dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [RW-1:0]      exp_q[$];
    obs_state_e         m_state;
    logic [TS_W-1:0]    m_ts;
    logic [PROBE_W-1:0] m_prev;
    logic               m_first;
    logic               m_ovf;
    logic [TS_W-1:0]    m_last_ts;
    logic [PROBE_W-1:0] m_last_probe;
    int                 n_checks;
    int                 n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_v);
        logic [TS2_W-1:0] ts2;
        ts2 = m_last_ts[TS2_W-1:0];
        chk("rd_valid",   32'(rd_valid),   32'(exp_v));
        chk("rd_ts",      32'(rd_ts),      32'(m_last_ts));
        chk("rd_probe",   32'(rd_probe),   32'(m_last_probe));
        chk("count",      32'(count),      32'(exp_q.size()));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("capturing",  32'(capturing),  32'(m_state == CAPTURE));
        chk("state",      32'(dbg_state),  32'(m_state));
        chk("rd_valid4",  32'(rd_valid2),  32'(exp_v));
        chk("rd_ts4",     32'(rd_ts2),     32'(ts2));
        chk("rd_probe4",  32'(rd_probe2),  32'(m_last_probe));
        chk("count4",     32'(count2),     32'(exp_q.size()));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state      = IDLE;
        m_ts         = '0;
        m_prev       = '0;
        m_first      = 1'b0;
        m_ovf        = 1'b0;
        m_last_ts    = '0;
        m_last_probe = '0;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases it.
    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // driver: one clock cycle with the given inputs, expectations updated first
    task automatic step(input logic [PROBE_W-1:0] p, input logic a, input logic s, input logic r);
        logic          exp_v;
        logic [RW-1:0] rec;
        probe  = p;
        arm    = a;
        stop   = s;
        rd_req = r;
        exp_v  = 1'b0;
        if (a) begin
            exp_q.delete();
            m_ovf   = 1'b0;
            m_state = CAPTURE;
            m_ts    = '0;
            m_prev  = p;
            m_first = 1'b1;
        end else begin
            if (r && exp_q.size() > 0) begin
                rec          = exp_q.pop_front();
                exp_v        = 1'b1;
                m_last_ts    = rec[RW-1:PROBE_W];
                m_last_probe = rec[PROBE_W-1:0];
            end
            if (m_state == CAPTURE) begin
                if (m_first || p != m_prev) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({m_ts, p});
                    else m_ovf = 1'b1;
                end
                m_ts    = m_ts + 1'b1;
                m_prev  = p;
                m_first = 1'b0;
                if (s) m_state = STOPPED;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(exp_v);
    endtask

    task automatic drain(input int n, input logic [PROBE_W-1:0] p);
        for (int i = 0; i < n; i++) step(p, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        probe    = '0;
        arm      = 1'b0;
        stop     = 1'b0;
        rd_req   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // baseline only, read on empty buffer during baseline push is not bypassed
        step(3'b101, 1'b1, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0, 1'b1);
        step(3'b101, 1'b0, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0, 1'b1);
        chk("baseline_ts", 32'(rd_ts), 32'd0);
        chk("baseline_probe", 32'(rd_probe), 32'b101);

        // changes at ts 4 and 9, stop, later change ignored, drain with one extra read
        step(3'b101, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 10; k++)
            step((k < 4) ? 3'b101 : (k < 9) ? 3'b001 : 3'b011, 1'b0, (k == 10), 1'b0);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        step(3'b110, 1'b0, 1'b0, 1'b0);
        chk("three_records", 32'(count), 32'd3);
        drain(4, 3'b110);

        // change every cycle without reads: overflow after eight records
        step(3'b000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) step(3'(k), 1'b0, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);

        // arm with rd_req on a full buffer: flush wins, no read
        step(3'b000, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) step(3'(k), 1'b0, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b1);
        chk("full_pop_push_count", 32'(count), 32'd8);
        chk("full_pop_push_ovf", 32'(overflow), 32'd0);
        step(3'b001, 1'b0, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b1, 1'b0);
        drain(10, 3'b001);

        // timestamp wrap on the 4-bit instance
        step(3'b000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 17; k++) step((k == 17) ? 3'b010 : 3'b000, 1'b0, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b1, 1'b0);
        drain(2, 3'b010);
        chk("wrap_ts4", 32'(rd_ts2), 32'd1);
        chk("wrap_ts16", 32'(rd_ts), 32'd17);

        // reset mid-capture with five buffered records
        step(3'b000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(3'(k), 1'b0, 1'b0, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd5);
        do_reset();
        step(3'b000, 1'b0, 1'b0, 1'b1);
        step(3'b101, 1'b1, 1'b1, 1'b0);
        chk("arm_beats_stop", 32'(capturing), 32'd1);
        step(3'b101, 1'b0, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
